// File: rtl/glitc_intercom_pkg.sv
// Shared definitions for the GLITC intercom transmit scheduler.
// Holds the word type codes carried on command_o, the internal scheduler
// states, the field widths of the 20-bit serializer word, and a helper
// that maps the internal state onto the 2-bit externally reported code.
package glitc_intercom_pkg;

  localparam int CMD_W     = 2;
  localparam int CORR_W    = 6;
  localparam int POWER_W   = 12;
  localparam int PAYLOAD_W = CORR_W + POWER_W;

  typedef enum logic [CMD_W-1:0] {
    WORD_IDLE  = 2'b00,
    WORD_DATA  = 2'b01,
    WORD_CMD   = 2'b10,
    WORD_TRAIN = 2'b11
  } word_type_e;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_TRAIN  = 3'd4
  } state_e;

  // RUN and TRAIN share the external code 11; train_ack_o tells them apart.
  function automatic logic [1:0] state_code(input state_e s);
    case (s)
      ST_OFF:    return 2'b00;
      ST_RESET:  return 2'b01;
      ST_SETTLE: return 2'b10;
      default:   return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/glitc_intercom_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   sysclk_i  clock
//   rst_i     synchronous active-high reset (count -> 0)
//   clr       synchronous clear (count -> 0), wins over inc
//   inc       increment by one, holding at MAX
//   count     current value
module glitc_intercom_sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             sysclk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v >= MAX) ? MAX : v + 1'b1;
  endfunction

  always_ff @(posedge sysclk_i) begin
    if (rst_i || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/glitc_intercom_tx_scheduler.sv
// GLITC intercom transmit scheduler.
// Brings the serializer up (reset hold, enable, settle with IDLE words) and
// then emits one registered 20-bit word per cycle chosen from trigger data,
// the link training pattern and slow-control commands. A pending command
// denied CMD_STARVE cycles in a row is granted over trigger data.
// Ports:
//   sysclk_i, rst_i          clock, synchronous active-high reset
//   start_i, stop_i          bring-up request / return to OFF (stop wins)
//   train_req_i, train_ack_o training request / training pattern on wire
//   data_valid_i, corr_in_i, power_in_i  trigger data word
//   cmd_valid_i, cmd_data_i, cmd_ready_o slow-control handshake
//   oserdes_rst_o, oserdes_en_o          serializer reset / enable
//   command_o, corr_o, power_o           registered serializer word
//   drop_cnt_o               saturating count of dropped trigger words
//   state_o                  00 OFF, 01 RESET, 10 SETTLE, 11 RUN/TRAIN
module glitc_intercom_tx_scheduler
  import glitc_intercom_pkg::*;
#(
  parameter int                   RST_CYCLES    = 8,
  parameter int                   SETTLE_CYCLES = 16,
  parameter int                   CMD_STARVE    = 32,
  parameter logic [PAYLOAD_W-1:0] TRAIN_PATTERN = 18'h2A5C3
) (
  input  logic                 sysclk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 train_req_i,
  output logic                 train_ack_o,
  input  logic                 data_valid_i,
  input  logic [CORR_W-1:0]    corr_in_i,
  input  logic [POWER_W-1:0]   power_in_i,
  input  logic                 cmd_valid_i,
  input  logic [PAYLOAD_W-1:0] cmd_data_i,
  output logic                 cmd_ready_o,
  output logic                 oserdes_rst_o,
  output logic                 oserdes_en_o,
  output logic [CMD_W-1:0]     command_o,
  output logic [CORR_W-1:0]    corr_o,
  output logic [POWER_W-1:0]   power_o,
  output logic [15:0]          drop_cnt_o,
  output logic [1:0]           state_o
);

  localparam int CNT_MAX  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int STARVE_W = $clog2(CMD_STARVE + 1);

  localparam logic [CNT_W-1:0]    RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(CMD_STARVE);

  state_e                 state, state_nxt;
  logic [CNT_W-1:0]       phase_cnt;
  logic [STARVE_W-1:0]    starve_cnt;
  logic                   starve_full;
  logic                   run_active;
  logic                   forced_grant;
  word_type_e             word_nxt;
  logic [PAYLOAD_W-1:0]   payload_nxt;
  word_type_e             command_p1;
  logic [PAYLOAD_W-1:0]   payload_p1;

  // RUN and TRAIN both count as the operational phase for scheduling.
  assign run_active   = (state == ST_RUN) || (state == ST_TRAIN);
  assign starve_full  = (starve_cnt == STARVE_MAX);
  assign cmd_ready_o  = !rst_i && run_active && cmd_valid_i &&
                        (!data_valid_i || starve_full) && !train_req_i && !stop_i;
  assign forced_grant = cmd_ready_o && starve_full;

  always_comb begin
    state_nxt = state;
    if (stop_i) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:    if (start_i)                  state_nxt = ST_RESET;
        ST_RESET:  if (phase_cnt == RST_LAST)    state_nxt = ST_SETTLE;
        ST_SETTLE: if (phase_cnt == SETTLE_LAST) state_nxt = ST_RUN;
        ST_RUN:    if (train_req_i)              state_nxt = ST_TRAIN;
        ST_TRAIN:  if (!train_req_i)             state_nxt = ST_RUN;
        default:                                 state_nxt = ST_OFF;
      endcase
    end
  end

  // Word selection is made against the next state so the word registered on
  // the RUN->TRAIN edge is already the training pattern.
  always_comb begin
    word_nxt    = WORD_IDLE;
    payload_nxt = '0;
    if (state_nxt == ST_TRAIN) begin
      word_nxt    = WORD_TRAIN;
      payload_nxt = TRAIN_PATTERN;
    end else if (run_active && !stop_i) begin
      // A grant alongside valid data only happens when forced, so a plain
      // grant check covers both command priorities.
      if (cmd_ready_o) begin
        word_nxt    = WORD_CMD;
        payload_nxt = cmd_data_i;
      end else if (data_valid_i) begin
        word_nxt    = WORD_DATA;
        payload_nxt = {corr_in_i, power_in_i};
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i || (state_nxt != state)) begin
      phase_cnt <= '0;
    end else if ((state == ST_RESET) || (state == ST_SETTLE)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Stage p1: registered word and serializer control.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state         <= ST_OFF;
      oserdes_rst_o <= 1'b1;
      oserdes_en_o  <= 1'b0;
      train_ack_o   <= 1'b0;
      command_p1    <= WORD_IDLE;
      payload_p1    <= '0;
    end else begin
      state         <= state_nxt;
      oserdes_rst_o <= (state_nxt == ST_OFF) || (state_nxt == ST_RESET);
      oserdes_en_o  <= !((state_nxt == ST_OFF) || (state_nxt == ST_RESET));
      train_ack_o   <= (state_nxt == ST_TRAIN);
      command_p1    <= word_nxt;
      payload_p1    <= payload_nxt;
    end
  end

  assign command_o = command_p1;
  assign corr_o    = payload_p1[PAYLOAD_W-1:POWER_W];
  assign power_o   = payload_p1[POWER_W-1:0];
  assign state_o   = state_code(state);

  glitc_intercom_sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .sysclk_i (sysclk_i),
    .rst_i    (rst_i),
    .clr      (!run_active || !cmd_valid_i || cmd_ready_o),
    .inc      (run_active && cmd_valid_i && !cmd_ready_o),
    .count    (starve_cnt)
  );

  // Trigger words lost to training, a forced command, or a stop are counted.
  glitc_intercom_sat_counter #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_drop_cnt (
    .sysclk_i (sysclk_i),
    .rst_i    (rst_i),
    .clr      (1'b0),
    .inc      (run_active && data_valid_i && (stop_i || train_req_i || forced_grant)),
    .count    (drop_cnt_o)
  );

endmodule

// File: tb/tb_glitc_intercom_tx_scheduler.sv
module tb_glitc_intercom_tx_scheduler;

  localparam int          RST_CYCLES    = 8;
  localparam int          SETTLE_CYCLES = 16;
  localparam int          CMD_STARVE    = 32;
  localparam logic [17:0] TRAIN_PATTERN = 18'h2A5C3;

  localparam int M_OFF = 0, M_RESET = 1, M_SETTLE = 2, M_RUN = 3, M_TRAIN = 4;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0, train_req = 1'b0;
  logic        data_valid = 1'b0, cmd_valid = 1'b0;
  logic [5:0]  corr_in = '0;
  logic [11:0] power_in = '0;
  logic [17:0] cmd_data = '0;
  logic        train_ack, cmd_ready, oserdes_rst, oserdes_en;
  logic [1:0]  command, state_code;
  logic [5:0]  corr;
  logic [11:0] power;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_mode = M_OFF, m_cnt = 0, m_starve = 0, m_drop = 0;
  logic [1:0]  m_cmd = 2'b00;
  logic [17:0] m_pay = '0;
  logic        m_ready;
  logic        last_ready;

  always #5 sysclk = ~sysclk;

  glitc_intercom_tx_scheduler #(
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CMD_STARVE    (CMD_STARVE),
    .TRAIN_PATTERN (TRAIN_PATTERN)
  ) dut (
    .sysclk_i      (sysclk),
    .rst_i         (rst),
    .start_i       (start),
    .stop_i        (stop),
    .train_req_i   (train_req),
    .train_ack_o   (train_ack),
    .data_valid_i  (data_valid),
    .corr_in_i     (corr_in),
    .power_in_i    (power_in),
    .cmd_valid_i   (cmd_valid),
    .cmd_data_i    (cmd_data),
    .cmd_ready_o   (cmd_ready),
    .oserdes_rst_o (oserdes_rst),
    .oserdes_en_o  (oserdes_en),
    .command_o     (command),
    .corr_o        (corr),
    .power_o       (power),
    .drop_cnt_o    (drop_cnt),
    .state_o       (state_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scheduler rules applied to one clock edge with the currently held inputs.
  task automatic model_edge();
    int  nm;
    bit  run;
    if (rst) begin
      m_mode = M_OFF; m_cnt = 0; m_starve = 0; m_drop = 0;
      m_cmd = 2'b00; m_pay = '0;
      return;
    end
    run = (m_mode == M_RUN) || (m_mode == M_TRAIN);
    if (stop) nm = M_OFF;
    else begin
      case (m_mode)
        M_OFF:    nm = start ? M_RESET : M_OFF;
        M_RESET:  nm = (m_cnt + 1 == RST_CYCLES) ? M_SETTLE : M_RESET;
        M_SETTLE: nm = (m_cnt + 1 == SETTLE_CYCLES) ? M_RUN : M_SETTLE;
        default:  nm = train_req ? M_TRAIN : M_RUN;
      endcase
    end
    if (nm == M_TRAIN) begin
      m_cmd = 2'b11; m_pay = TRAIN_PATTERN;
    end else if (run && !stop && m_ready) begin
      m_cmd = 2'b10; m_pay = cmd_data;
    end else if (run && !stop && data_valid) begin
      m_cmd = 2'b01; m_pay = {corr_in, power_in};
    end else begin
      m_cmd = 2'b00; m_pay = '0;
    end
    if (run && data_valid && (stop || train_req || (m_ready && m_starve == CMD_STARVE)))
      m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
    if (run && cmd_valid && !m_ready)
      m_starve = (m_starve < CMD_STARVE) ? m_starve + 1 : m_starve;
    else
      m_starve = 0;
    m_cnt  = (nm != m_mode) ? 0 : m_cnt + 1;
    m_mode = nm;
  endtask

  // One clock: check cmd_ready before the edge, advance model, check outputs.
  task automatic tick();
    #1;
    m_ready = !rst && (m_mode == M_RUN || m_mode == M_TRAIN) && cmd_valid &&
              (!data_valid || m_starve == CMD_STARVE) && !train_req && !stop;
    last_ready = cmd_ready;
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
    @(posedge sysclk);
    model_edge();
    #1;
    check("state", {30'd0, state_code}, (m_mode == M_TRAIN) ? 32'd3 : m_mode);
    check("oserdes_rst", {31'd0, oserdes_rst}, {31'd0, m_mode <= M_RESET});
    check("oserdes_en", {31'd0, oserdes_en}, {31'd0, m_mode >= M_SETTLE});
    check("train_ack", {31'd0, train_ack}, {31'd0, m_mode == M_TRAIN});
    check("command", {30'd0, command}, {30'd0, m_cmd});
    check("payload", {14'd0, corr, power}, {14'd0, m_pay});
    check("drop_cnt", {16'd0, drop_cnt}, m_drop);
  endtask

  task automatic rand_fields();
    corr_in  = 6'($urandom);
    power_in = 12'($urandom);
    cmd_data = 18'($urandom);
  endtask

  initial begin
    int rst_hi, en_hi, words;

    @(negedge sysclk);
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_state", {30'd0, state_code}, 32'd0);
    check("rst_oserdes_rst", {31'd0, oserdes_rst}, 32'd1);
    check("rst_command", {30'd0, command}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;

    // Bring-up with trigger data present throughout
    start = 1'b1; data_valid = 1'b1; rand_fields();
    tick();
    start = 1'b0;
    rst_hi = 0; en_hi = 0; words = 0;
    rst_hi += oserdes_rst; en_hi += oserdes_en; words += (command != 2'b00);
    for (int i = 0; i < RST_CYCLES + SETTLE_CYCLES - 1; i++) begin
      rand_fields();
      tick();
      rst_hi += oserdes_rst; en_hi += oserdes_en; words += (command != 2'b00);
    end
    check("bringup_rst_cycles", rst_hi, RST_CYCLES);
    check("bringup_en_cycles", en_hi, SETTLE_CYCLES);
    check("bringup_non_idle", words, 32'd0);
    tick();
    check("bringup_run", {30'd0, state_code}, 32'd3);
    check("bringup_drop", {16'd0, drop_cnt}, 32'd0);

    // Plain data word
    data_valid = 1'b1; corr_in = 6'h15; power_in = 12'hABC;
    tick();
    check("data_cmd", {30'd0, command}, 32'd1);
    check("data_corr", {26'd0, corr}, 32'h15);
    check("data_power", {20'd0, power}, 32'hABC);

    // Data and command together: data wins
    cmd_valid = 1'b1; rand_fields();
    tick();
    check("both_ready", {31'd0, last_ready}, 32'd0);
    check("both_cmd", {30'd0, command}, 32'd1);
    cmd_valid = 1'b0; data_valid = 1'b0;
    tick();

    // Starvation: forced grant on the 33rd consecutive cycle
    cmd_valid = 1'b1; data_valid = 1'b1;
    for (int i = 1; i <= CMD_STARVE + 1; i++) begin
      rand_fields();
      tick();
      check("starve_ready", {31'd0, last_ready}, {31'd0, i == CMD_STARVE + 1});
    end
    check("forced_cmd", {30'd0, command}, 32'd2);
    check("forced_payload", {14'd0, corr, power}, {14'd0, cmd_data});
    check("forced_drop", {16'd0, drop_cnt}, 32'd1);
    cmd_valid = 1'b0;

    // Training for five cycles with data present
    train_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      tick();
      check("train_word", {12'd0, command, corr, power}, {12'd0, 2'b11, TRAIN_PATTERN});
      check("train_ack", {31'd0, train_ack}, 32'd1);
    end
    train_req = 1'b0; rand_fields();
    tick();
    check("train_exit_data", {30'd0, command}, 32'd1);
    check("train_drop", {16'd0, drop_cnt}, 32'd6);

    // Stop during training with start also high
    data_valid = 1'b0; train_req = 1'b1;
    tick();
    stop = 1'b1; start = 1'b1;
    tick();
    check("stop_state", {30'd0, state_code}, 32'd0);
    check("stop_rst", {31'd0, oserdes_rst}, 32'd1);
    check("stop_en", {31'd0, oserdes_en}, 32'd0);
    check("stop_ack", {31'd0, train_ack}, 32'd0);
    stop = 1'b0; start = 1'b0; train_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) train_req = ~train_req;
      data_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) cmd_valid = ~cmd_valid;
      rand_fields();
      tick();
    end

    // Drop counter saturation
    stop = 1'b0; train_req = 1'b0; cmd_valid = 1'b0; data_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_pre_clear", {16'd0, drop_cnt}, 32'd0);
    start = 1'b1;
    for (int i = 0; i < 100 && m_mode != M_RUN; i++) tick();
    start = 1'b0;
    check("reach_run", {30'd0, state_code}, 32'd3);
    train_req = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    check("sat_drop", {16'd0, drop_cnt}, 32'hFFFF);
    rst = 1'b1;
    tick();
    check("sat_cleared", {16'd0, drop_cnt}, 32'd0);
    check("sat_state", {30'd0, state_code}, 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
